// File: rtl/maxpool_window_counter.sv
// Raster-position tracker for the maxpool datapath: column/row counters over a
// runtime-configured frame, window phase, output-grid indices and per-pixel strobes.
module maxpool_window_counter #(
  parameter int DATA_WIDTH = 14,
  parameter int POOL_SIZE  = 2,
  parameter int LOG2_POOL  = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] Cfg_Width,
  input  logic [DATA_WIDTH-1:0] Cfg_Height,
  input  logic                  En,
  output logic                  Busy,
  output logic                  Cfg_Err,
  output logic [DATA_WIDTH-1:0] Col_Idx,
  output logic [DATA_WIDTH-1:0] Row_Idx,
  output logic [DATA_WIDTH-1:0] Out_Col,
  output logic [DATA_WIDTH-1:0] Out_Row,
  output logic                  Col_First,
  output logic                  Row_First,
  output logic                  Win_Last,
  output logic                  Row_End,
  output logic                  Frame_End
);

  if ((1 << LOG2_POOL) != POOL_SIZE || POOL_SIZE < 2 || POOL_SIZE > 16) begin : g_bad_pool
    $error("POOL_SIZE must be a power of two in 2..16 matching LOG2_POOL");
  end

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DATA_WIDTH-1:0] POOL_MASK = DATA_WIDTH'(POOL_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] POOL_DW   = DATA_WIDTH'(POOL_SIZE);
  localparam logic [DATA_WIDTH-1:0] ONE_DW    = DATA_WIDTH'(1);
  localparam logic [LOG2_POOL-1:0]  PH_MAX    = '1;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] w_q, w_d, h_q, h_d;
  logic [DATA_WIDTH-1:0] col_q, col_d, row_q, row_d;
  logic [LOG2_POOL-1:0]  cph_q, cph_d, rph_q, rph_d;
  logic                  err_q, err_d;

  logic                  consume, col_last, row_last, cfg_bad;
  logic [DATA_WIDTH-1:0] wlim, hlim;

  assign consume  = (state_q == RUN) & En;
  assign col_last = (col_q == w_q - ONE_DW);
  assign row_last = (row_q == h_q - ONE_DW);
  assign cfg_bad  = (Cfg_Width < POOL_DW) | (Cfg_Height < POOL_DW);
  // Floor mode: trailing columns/rows beyond the last full window never complete one.
  assign wlim     = w_q & ~POOL_MASK;
  assign hlim     = h_q & ~POOL_MASK;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cph_q   <= '0;
      rph_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cph_q   <= cph_d;
      rph_q   <= rph_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    row_d   = row_q;
    cph_d   = cph_q;
    rph_d   = rph_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            w_d     = Cfg_Width;
            h_d     = Cfg_Height;
            col_d   = '0;
            row_d   = '0;
            cph_d   = '0;
            rph_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (consume) begin
          if (col_last) begin
            col_d = '0;
            cph_d = '0;
            if (row_last) begin
              row_d   = '0;
              rph_d   = '0;
              state_d = IDLE;
            end else begin
              // Phase is LOG2_POOL wide, so it wraps at POOL_SIZE-1 on its own.
              row_d = row_q + ONE_DW;
              rph_d = rph_q + 1'b1;
            end
          end else begin
            col_d = col_q + ONE_DW;
            cph_d = cph_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy      = (state_q == RUN);
  assign Cfg_Err   = err_q;
  assign Col_Idx   = col_q;
  assign Row_Idx   = row_q;
  assign Out_Col   = col_q >> LOG2_POOL;
  assign Out_Row   = row_q >> LOG2_POOL;
  assign Col_First = (cph_q == '0);
  assign Row_First = (rph_q == '0);
  assign Win_Last  = consume & (cph_q == PH_MAX) & (rph_q == PH_MAX) &
                     (col_q < wlim) & (row_q < hlim);
  assign Row_End   = consume & col_last;
  assign Frame_End = consume & col_last & row_last;

endmodule

// File: tb/tb_maxpool_window_counter.sv
// Scoreboard bench for maxpool_window_counter: POOL_SIZE=2 and POOL_SIZE=4 instances,
// per-pixel expectations queued by stimulus and popped by a negedge monitor.
module tb_maxpool_window_counter;
  localparam int DW = 14;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic          st2 = 0, en2 = 0, st4 = 0, en4 = 0;
  logic [DW-1:0] w2 = '0, h2 = '0, w4 = '0, h4 = '0;
  logic          busy2, err2, cf2, rf2, wl2, re2, fe2;
  logic          busy4, err4, cf4, rf4, wl4, re4, fe4;
  logic [DW-1:0] col2, row2, ocol2, orow2, col4, row4, ocol4, orow4;

  maxpool_window_counter #(.DATA_WIDTH(DW), .POOL_SIZE(2), .LOG2_POOL(1)) u_p2 (
    .Clk(Clk), .Rst(Rst), .Start(st2), .Cfg_Width(w2), .Cfg_Height(h2), .En(en2),
    .Busy(busy2), .Cfg_Err(err2), .Col_Idx(col2), .Row_Idx(row2), .Out_Col(ocol2),
    .Out_Row(orow2), .Col_First(cf2), .Row_First(rf2), .Win_Last(wl2), .Row_End(re2),
    .Frame_End(fe2));

  maxpool_window_counter #(.DATA_WIDTH(DW), .POOL_SIZE(4), .LOG2_POOL(2)) u_p4 (
    .Clk(Clk), .Rst(Rst), .Start(st4), .Cfg_Width(w4), .Cfg_Height(h4), .En(en4),
    .Busy(busy4), .Cfg_Err(err4), .Col_Idx(col4), .Row_Idx(row4), .Out_Col(ocol4),
    .Out_Row(orow4), .Col_First(cf4), .Row_First(rf4), .Win_Last(wl4), .Row_End(re4),
    .Frame_End(fe4));

  typedef logic [4*DW+4:0] rec_t;  // {col,row,ocol,orow,cf,rf,wl,re,fe}
  rec_t q2[$];
  rec_t q4[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per consumed pixel; strobes must be quiet otherwise.
  always @(negedge Clk) begin
    if (busy2 && en2) begin
      if (q2.size() == 0) chk("p2_unexpected_pixel", 1, 0);
      else chk("p2_pixel", {col2, row2, ocol2, orow2, cf2, rf2, wl2, re2, fe2}, q2.pop_front());
    end else begin
      chk("p2_idle_strobes", {wl2, re2, fe2}, 3'b000);
    end
    if (busy4 && en4) begin
      if (q4.size() == 0) chk("p4_unexpected_pixel", 1, 0);
      else chk("p4_pixel", {col4, row4, ocol4, orow4, cf4, rf4, wl4, re4, fe4}, q4.pop_front());
    end else begin
      chk("p4_idle_strobes", {wl4, re4, fe4}, 3'b000);
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_start(input int sel, input logic v, input int W, input int H);
    if (sel == 2) begin st2 = v; w2 = DW'(W); h2 = DW'(H); end
    else          begin st4 = v; w4 = DW'(W); h4 = DW'(H); end
  endtask

  task automatic set_en(input int sel, input logic v);
    if (sel == 2) en2 = v; else en4 = v;
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 2) ? busy2 : busy4;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 2) ? err2 : err4;
  endfunction

  // wl: hand-listed raster indices that complete a window. start_at: pixel index at
  // which an illegal Start is also driven (must be ignored while running), -1 for none.
  task automatic run_frame(input int sel, input int W, input int H, input logic [63:0] wl,
                           input bit gap, input int start_at);
    int P;
    P = sel;
    set_start(sel, 1'b1, W, H);
    cyc();
    set_start(sel, 1'b0, 0, 0);
    chk("busy_after_start", get_busy(sel), 1'b1);
    for (int i = 0; i < W * H; i++) begin
      int c, r;
      rec_t e;
      c = i % W;
      r = i / W;
      e = {DW'(c), DW'(r), DW'(c / P), DW'(r / P), 1'((c % P) == 0), 1'((r % P) == 0),
           wl[i], 1'(c == W - 1), 1'(i == W * H - 1)};
      if (sel == 2) q2.push_back(e); else q4.push_back(e);
      set_en(sel, 1'b1);
      if (i == start_at) set_start(sel, 1'b1, 1, 1);
      cyc();
      if (i == start_at) begin
        set_start(sel, 1'b0, 0, 0);
        chk("start_in_run_no_err", get_err(sel), 1'b0);
        chk("start_in_run_busy", get_busy(sel), 1'b1);
      end
      if (i == W * H - 1) chk("busy_falls", get_busy(sel), 1'b0);
      if (gap) begin
        set_en(sel, 1'b0);
        cyc();
      end
    end
    set_en(sel, 1'b0);
    cyc();
    chk("idle_after_frame", get_busy(sel), 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy2, 1'b0);
    chk("rst_err", err2, 1'b0);
    chk("rst_col_row", {col2, row2, ocol2, orow2}, '0);
    chk("rst_first", {cf2, rf2, cf4, rf4}, 4'b1111);
    chk("rst_strobes", {wl2, re2, fe2, wl4, re4, fe4}, 6'b0);
    Rst = 1'b0;
    cyc();

    // 4x4, En held high: windows close at 5,7,13,15.
    run_frame(2, 4, 4, 64'h0000_0000_0000_A0A0, 1'b0, -1);
    // 5x3 floor mode: only (1,1)=6 and (1,3)=8 close; an illegal Start mid-frame.
    run_frame(2, 5, 3, 64'h0000_0000_0000_0140, 1'b0, 3);
    // 4x4 with En toggling: same strobe pattern.
    run_frame(2, 4, 4, 64'h0000_0000_0000_A0A0, 1'b1, -1);

    // Rejected config.
    set_start(2, 1'b1, 1, 8);
    cyc();
    set_start(2, 1'b0, 0, 0);
    chk("cfg_err_pulse", err2, 1'b1);
    chk("cfg_err_busy", busy2, 1'b0);
    cyc();
    chk("cfg_err_clears", err2, 1'b0);
    chk("cfg_err_still_idle", busy2, 1'b0);

    // Reset after 6 pixels of a 4x4 frame.
    set_start(2, 1'b1, 4, 4);
    cyc();
    set_start(2, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      rec_t e;
      e = {DW'(i % 4), DW'(i / 4), DW'((i % 4) / 2), DW'((i / 4) / 2),
           1'((i % 2) == 0), 1'(((i / 4) % 2) == 0), 1'(i == 5), 1'(i == 3), 1'b0};
      q2.push_back(e);
      en2 = 1'b1;
      cyc();
    end
    Rst = 1'b1;
    #1;
    chk("midrst_busy", busy2, 1'b0);
    chk("midrst_counters", {col2, row2}, '0);
    chk("midrst_no_frame_end", {fe2, wl2, re2}, 3'b000);
    chk("midrst_first", {cf2, rf2}, 2'b11);
    en2 = 1'b0;
    cyc();
    Rst = 1'b0;
    cyc();
    run_frame(2, 4, 4, 64'h0000_0000_0000_A0A0, 1'b0, -1);

    // POOL_SIZE=4, 8x4: windows close at 27 and 31.
    run_frame(4, 8, 4, 64'h0000_0000_8800_0000, 1'b0, -1);

    cyc();
    chk("q2_drained", q2.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/maxpool_window_counter.md
Name: maxpool_window_counter

Overview:
- Parametrised raster-position tracker for the maxpool datapath; generalises the single-bit even/odd column toggle.
- Tracks pixel column and row over a runtime-configured frame, plus window phase for a POOL_SIZE x POOL_SIZE window.
- Emits per-pixel window first/last strobes, output-grid indices and row/frame end strobes.
- Drives the max comparator's load/compare select and output-valid.

Parameters:
- DATA_WIDTH, 14, width of the column/row counters and config inputs.
- POOL_SIZE, 2, window edge and stride. Must be a power of two, 2..16.
- LOG2_POOL, 1, log2(POOL_SIZE). Must be consistent with POOL_SIZE.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous active-high reset.
- Start  input  1  starts a frame; sampled in IDLE only.
- Cfg_Width  input  DATA_WIDTH  frame width in pixels; latched on accepted Start.
- Cfg_Height  input  DATA_WIDTH  frame height in pixels; latched on accepted Start.
- En  input  1  pixel valid; one pixel is consumed per cycle with En=1 in RUN.
- Busy  output  1  high in RUN.
- Cfg_Err  output  1  one-cycle pulse when Start is rejected.
- Col_Idx  output  DATA_WIDTH  column of the next pixel.
- Row_Idx  output  DATA_WIDTH  row of the next pixel.
- Out_Col  output  DATA_WIDTH  Col_Idx >> LOG2_POOL.
- Out_Row  output  DATA_WIDTH  Row_Idx >> LOG2_POOL.
- Col_First  output  1  column phase == 0 (level).
- Row_First  output  1  row phase == 0 (level).
- Win_Last  output  1  strobe: the consumed pixel completes a full window.
- Row_End  output  1  strobe: the consumed pixel is the last in its row.
- Frame_End  output  1  strobe: the consumed pixel is the last in the frame.

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE.
  - All counters and phases = 0; latched Width/Height = 0.
  - Busy=0, Cfg_Err=0.
  - Col_First=1, Row_First=1 (phases are 0).
  - All strobes = 0.
- States: IDLE, RUN.
- IDLE, Start=1:
  - If Cfg_Width < POOL_SIZE or Cfg_Height < POOL_SIZE: Cfg_Err=1 next cycle for one cycle; stay IDLE.
  - Otherwise: latch W and H, clear counters, go to RUN; Busy=1 next cycle.
- En in IDLE is ignored. Start in RUN is ignored; no Cfg_Err.
- Pixel consumed = (state==RUN) & En. Counters advance only on a consumed pixel; they hold otherwise, including during En gaps.
- On a consumed pixel:
  - Col_Idx+1 and col phase+1, phase wrapping at POOL_SIZE-1 -> 0.
  - If Col_Idx==W-1: Col_Idx=0, col phase=0, Row_Idx+1, row phase+1 (wraps likewise).
- Frame end: consumed pixel with Col_Idx==W-1 and Row_Idx==H-1.
  - Frame_End=1 that cycle.
  - Next state IDLE; counters and phases return to 0.
- Strobes are combinational from the registered counters and gated by the consumed-pixel condition. Latency 0: they describe the pixel consumed in that cycle.
- Window completeness (floor mode):
  - Wlim = W & ~(POOL_SIZE-1); Hlim = H & ~(POOL_SIZE-1).
  - Win_Last = consumed & col phase==POOL_SIZE-1 & row phase==POOL_SIZE-1 & Col_Idx<Wlim & Row_Idx<Hlim.
  - Trailing partial columns and rows are consumed but never produce Win_Last.
- Row_End = consumed & Col_Idx==W-1. Row_End and Frame_End coincide on the final pixel.
- Col_First and Row_First are levels (not gated by En). Used as the comparator load-select.
- Simultaneous Rst and any input: reset wins.
- Rst asserted mid-frame: immediate return to IDLE; no Frame_End pulse.
- Arithmetic: counters never exceed W-1 / H-1, so no wrap beyond the configured frame. W = H = 2^DATA_WIDTH-1 is legal.

Test Plan:
- W=4, H=4, POOL_SIZE=2, En held high 16 cycles:
  - Win_Last on pixels 5, 7, 13, 15 (raster index from 0).
  - Row_End on 3, 7, 11, 15; Frame_End on 15.
  - Busy falls the next cycle.
- W=5, H=3, POOL_SIZE=2:
  - Win_Last only at (row 1, col 1) and (row 1, col 3).
  - Column 4 and row 2 never strobe; Frame_End at pixel 14.
- Same 4x4 frame with En toggling 1,0,1,0:
  - Counters hold on En=0; strobe sequence identical to the first test; 32 cycles total.
- Start with Cfg_Width=1, Cfg_Height=8:
  - Cfg_Err pulses one cycle; Busy stays 0.
  - Start during RUN: no effect, counters undisturbed.
- Rst pulsed after 6 pixels of a 4x4 frame:
  - Outputs immediately at reset values; no Frame_End.
  - A new Start runs a clean full frame.
- POOL_SIZE=4, LOG2_POOL=2, W=8, H=4:
  - Win_Last on pixels 27 and 31.
  - Out_Col=1 for columns 4..7.
  - Col_First high at columns 0 and 4.
